// File: rtl/aud_pwm_stream_pkg.sv
// Shared types and helpers for the streaming audio PWM block.
// Holds the FSM state type, the midscale function and the underrun counter width.
package aud_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int UNDERRUN_CNT_W = 16;

  function automatic logic [31:0] midscale(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/aud_frame_fifo.sv
// Frame FIFO: synchronous, power-of-two depth, read data shown at rd_ptr.
// Ports: clk, rst, wr_data/wr_en, rd_en/rd_data, full, empty, level.
module aud_frame_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/aud_pwm_stream.sv
// Streaming multi-channel PWM audio output fed by a frame FIFO.
// Ports: clk, rst, start, s_data/s_valid/s_ready, aud_pwm, playing,
// underrun, fifo_level; underrun_cnt when AUD_PWM_STREAM_UNDERRUN_CNT_EN.
module aud_pwm_stream
  import aud_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int PRESCALE   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [NUM_CH-1:0]              aud_pwm,
  output logic                           playing,
  output logic                           underrun,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
`ifdef AUD_PWM_STREAM_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0]      underrun_cnt
`endif
);

  localparam int FW = NUM_CH * DATA_WIDTH;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DATA_WIDTH-1:0] MID =
    DATA_WIDTH'(midscale(DATA_WIDTH));

  state_t                state;
  logic [PW-1:0]         presc;
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] duty [NUM_CH];
  logic [FW-1:0]         rd_data;
  logic                  full;
  logic                  empty;
  logic                  tick;
  logic                  wrap;
  logic                  pop;
  logic                  need_mid;

  aud_frame_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (s_data),
    .wr_en   (s_valid),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign s_ready  = !full;
  assign playing  = (state == PLAY);
  assign tick     = playing && (presc == PW'(PRESCALE - 1));
  assign wrap     = tick && (count == '1);
  // A stop request at the wrap suppresses both the pop and the underrun.
  assign pop      = (state == LOAD) || (wrap && start && !empty);
  assign need_mid = wrap && start && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      count    <= '0;
      aud_pwm  <= '0;
      underrun <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) duty[c] <= '0;
    end else begin
      underrun <= need_mid;
      for (int c = 0; c < NUM_CH; c++) begin
        aud_pwm[c] <= playing && (count < duty[c]);
        if (pop)
          duty[c] <= rd_data[c*DATA_WIDTH +: DATA_WIDTH];
        else if (need_mid)
          duty[c] <= MID;
      end
      unique case (state)
        IDLE: begin
          presc <= '0;
          count <= '0;
          if (start && (fifo_level != '0)) state <= LOAD;
        end
        LOAD: begin
          presc <= '0;
          count <= '0;
          state <= PLAY;
        end
        PLAY: begin
          if (tick) begin
            presc <= '0;
            count <= count + 1'b1;
            if (wrap && !start) state <= IDLE;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AUD_PWM_STREAM_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      underrun_cnt <= '0;
    else if (need_mid && (underrun_cnt != '1))
      underrun_cnt <= underrun_cnt + 1'b1;
  end
`else
  // No underrun statistics in this build.
`endif

endmodule

// File: tb/tb_aud_pwm_stream.sv
// Directed self-checking bench for aud_pwm_stream.
// Config: DATA_WIDTH=8, NUM_CH=2, FIFO_DEPTH=4, PRESCALE=1.
module tb_aud_pwm_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [1:0]  aud_pwm;
  logic        playing;
  logic        underrun;
  logic [2:0]  fifo_level;
`ifdef AUD_PWM_STREAM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int ntests = 0;
  int nfail  = 0;

  aud_pwm_stream #(
    .DATA_WIDTH (8),
    .NUM_CH     (2),
    .FIFO_DEPTH (4),
    .PRESCALE   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .aud_pwm    (aud_pwm),
    .playing    (playing),
    .underrun   (underrun),
    .fifo_level (fifo_level)
`ifdef AUD_PWM_STREAM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int h0, h1, u, last_u, acc;
  logic hold;
  logic [15:0] fr [5];

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) step;
    chk("rst_pwm", 32'(aud_pwm), 0);
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst = 1'b0;

    // one frame, then two periods with start held
    s_data = {8'h40, 8'h00}; s_valid = 1'b1;
    step;
    s_valid = 1'b0;
    chk("push1_level", 32'(fifo_level), 1);
    start = 1'b1;
    step;
    chk("load_playing", 32'(playing), 0);
    step;
    chk("play_playing", 32'(playing), 1);
    chk("play_level", 32'(fifo_level), 0);

    h0 = 0; h1 = 0; u = 0; last_u = 0;
    for (int i = 0; i < 256; i++) begin
      step;
      h0 += int'(aud_pwm[0]);
      h1 += int'(aud_pwm[1]);
      u  += int'(underrun);
      if (i == 255) last_u = int'(underrun);
    end
    chk("p1_ch1_high", 32'(h1), 64);
    chk("p1_ch0_high", 32'(h0), 0);
    chk("p1_underruns", 32'(u), 1);
    chk("p1_underrun_at_wrap", 32'(last_u), 1);

    h0 = 0; h1 = 0; u = 0;
    for (int i = 0; i < 256; i++) begin
      step;
      h0 += int'(aud_pwm[0]);
      h1 += int'(aud_pwm[1]);
      u  += int'(underrun);
    end
    chk("p2_ch0_mid", 32'(h0), 128);
    chk("p2_ch1_mid", 32'(h1), 128);
    chk("p2_underruns", 32'(u), 1);
`ifdef AUD_PWM_STREAM_UNDERRUN_CNT_EN
    chk("underrun_cnt", 32'(underrun_cnt), 2);
`endif

    // stop at count 100 with a frame waiting: no truncation, no pop
    s_data = {8'h10, 8'h20}; s_valid = 1'b1;
    step;
    s_valid = 1'b0;
    repeat (99) step;
    start = 1'b0;
    u = 0; hold = 1'b1;
    for (int i = 0; i < 155; i++) begin
      step;
      u += int'(underrun);
      hold &= playing;
    end
    chk("stop_hold_playing", 32'(hold), 1);
    step;
    u += int'(underrun);
    chk("stop_idle", 32'(playing), 0);
    chk("stop_no_pop", 32'(fifo_level), 1);
    chk("stop_no_underrun", 32'(u), 0);
    chk("stop_pwm", 32'(aud_pwm), 0);

    // backpressure
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("bp_level0", 32'(fifo_level), 0);
    fr[0] = 16'hFFFF; fr[1] = 16'h8001; fr[2] = 16'h3333;
    fr[3] = 16'h4444; fr[4] = 16'h5555;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      s_data = fr[i]; s_valid = 1'b1;
      if (i == 4) chk("bp_ready_5th", 32'(s_ready), 0);
      if (s_ready) acc++;
      step;
    end
    s_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 4);
    chk("bp_level4", 32'(fifo_level), 4);
    chk("bp_ready_full", 32'(s_ready), 0);

    // full-scale duty, FIFO order, then reset mid-period
    start = 1'b1;
    step;
    step;
    chk("fs_level3", 32'(fifo_level), 3);
    h0 = 0; h1 = 0;
    for (int i = 0; i < 256; i++) begin
      step;
      h0 += int'(aud_pwm[0]);
      h1 += int'(aud_pwm[1]);
    end
    chk("fs_ch0_high", 32'(h0), 255);
    chk("fs_ch1_high", 32'(h1), 255);
    repeat (50) step;
    chk("order_pwm", 32'(aud_pwm), 32'b10);
    chk("order_level", 32'(fifo_level), 2);
    rst = 1'b1;
    step;
    chk("midrst_pwm", 32'(aud_pwm), 0);
    chk("midrst_level", 32'(fifo_level), 0);
    chk("midrst_playing", 32'(playing), 0);
    chk("midrst_ready", 32'(s_ready), 1);
`ifdef AUD_PWM_STREAM_UNDERRUN_CNT_EN
    chk("midrst_cnt", 32'(underrun_cnt), 0);
`endif
    rst = 1'b0; start = 1'b0;
    step;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
